// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core data port.
// Accepts one load/store at a time over a valid/ready request channel, waits
// WAIT_CYCLES, commits against a byte-lane RAM and answers over a valid/ready
// response channel. Optional macro DMEM_ALIGN_CHECK_EN adds misalignment faults.
// BASE_ADDR is expected to be word-aligned.

// One byte lane of the local RAM: synchronous write, combinational read.
module dmem_lane #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int VEC_W = 8
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [VEC_W-1:0] wdata_i,
    output logic [VEC_W-1:0] rdata_o
);
    logic [VEC_W-1:0] mem_q [DEPTH];

    // Lane write; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];
endmodule

module dmem_responder #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    req_t    req_q, req_d, req_in, cur;
    logic    rdy_q;
    logic [31:0] rdata_q, rdata_d;
    logic    err_q, err_d;
    logic    commit, fault, oor;
    logic [29:0] idx_full;
    logic [AW-1:0] idx;
    logic [NUM_LANES-1:0]            lane_we;
    logic [NUM_LANES-1:0][VEC_W-1:0] lane_wdata, lane_rdata;

    assign req_in = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, be: req_be_i};

    // With no wait states the commit happens on the acceptance edge, so it
    // must see the live request rather than the captured copy.
    assign cur = (state_q == IDLE) ? req_in : req_q;

    // Word index and range check; the top of the address space never wraps.
    assign idx_full = cur.addr[31:2] - BASE_ADDR[31:2];
    assign idx      = idx_full[AW-1:0];
    assign oor      = (cur.addr < BASE_ADDR) || (idx_full >= 30'(DEPTH));

`ifdef DMEM_ALIGN_CHECK_EN
    logic misalign;
    // Any offset faults; a store's lanes must also lie at or above the offset.
    always_comb begin
        misalign = (cur.addr[1:0] != 2'b00);
        if (cur.we && ((cur.be & ~(4'hF << cur.addr[1:0])) != 4'h0)) misalign = 1'b1;
    end
    assign fault = oor || misalign;
`else
    logic unused_lsb;
    assign unused_lsb = ^cur.addr[1:0];
    assign fault      = oor;
`endif

    // RAM as an array of byte lanes.
    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            assign lane_we[i]    = commit && cur.we && !fault && cur.be[i];
            assign lane_wdata[i] = cur.wdata[i*VEC_W +: VEC_W];
            dmem_lane #(.DEPTH(DEPTH), .AW(AW), .VEC_W(VEC_W)) u_lane (
                .clk_i   (clk_i),
                .we_i    (lane_we[i]),
                .addr_i  (idx),
                .wdata_i (lane_wdata[i]),
                .rdata_o (lane_rdata[i])
            );
        end
    endgenerate

    // Next-state, wait counter, capture and response data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i && rdy_q) begin
                    req_d = req_in;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d   = fault;
            rdata_d = (!fault && !cur.we) ? lane_rdata : '0;
        end
    end

    // State register; ready stays low until the first edge after reset release.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdy_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdy_q   <= 1'b1;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o = (state_q == IDLE) && rdy_q;
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipelined core's data port.
- Answers load/store requests issued by the core over a valid/ready request channel.
- Returns results over a valid/ready response channel after a programmable number of wait states.
- Holds a word-organised local RAM with byte-lane writes, bounds checking and error signalling, so the hazard logic can be exercised against a multi-cycle memory.

Parameters:
DEPTH, 256, number of 32-bit words in local RAM (power of two, >= 4)
WAIT_CYCLES, 2, extra cycles between request acceptance and response (0..15)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  1  core presents a request
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, lane-aligned
req_be  input  4  byte enables for store (bit i -> bits 8i+7:8i)
rsp_valid  output  1  response available
rsp_ready  input  1  core accepts response
rsp_rdata  output  32  load data; 0 for stores and errors
rsp_err  output  1  access fault (out of range, or misaligned when checked)

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; wait counter = 0.
  - req_ready=0 while rst asserted; req_ready=1 from the first clock edge after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - RAM contents are not reset.
- States are IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid=1, the request is accepted: addr, we, wdata and be are captured.
  - WAIT_CYCLES=0: go to RESP. Otherwise go to WAIT with counter = WAIT_CYCLES-1.
- WAIT:
  - req_ready=0, rsp_valid=0.
  - Counter decrements each cycle. At counter=0 go to RESP.
  - Request inputs are ignored.
- Commit happens on the edge that enters RESP:
  - Word index = (addr - BASE_ADDR) >> 2.
  - Fault when the index >= DEPTH or addr < BASE_ADDR. On a fault: no RAM update, rsp_err=1, rsp_rdata=0.
  - Store: write only the lanes with be set; rsp_rdata=0, rsp_err=0.
  - Store with be=4'b0000: no RAM change, normal response.
  - Load: rsp_rdata = full 32-bit word, rsp_err=0. Sign/zero extension is the core's job.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err are held stable while rsp_ready=0.
  - On rsp_ready=1 go to IDLE and clear rsp_valid, rsp_rdata and rsp_err on that edge.
- Latency: acceptance edge to rsp_valid high = WAIT_CYCLES+1 cycles.
  - Minimum occupancy per transaction = WAIT_CYCLES+2 cycles.
  - No new request is accepted in the cycle the response handshakes.
- Read-after-write: a load following a store to the same word returns the merged post-store word.
- Counter width is sized for WAIT_CYCLES and wraps never; only the values WAIT_CYCLES-1..0 are used.
- Reset mid-transaction: the transaction is dropped.
  - An uncommitted store (still in WAIT) never reaches RAM.
  - A committed store remains in RAM.
- Addresses at the top of the 32-bit space do not wrap; they fault as out of range.

Optional Feature:
Macro DMEM_ALIGN_CHECK_EN.
- Defined:
  - Load/store with req_addr[1:0]!=2'b00 faults (rsp_err=1, no write, rdata=0).
  - A store whose be has set bits not contained in the lanes selected by addr[1:0] upward also faults. Example: addr[1:0]=2'b10 with be=4'b0011.
- Undefined:
  - req_addr[1:0] is ignored for indexing and checking; be alone selects lanes.
  - Misalignment never causes rsp_err.

Test Plan:
- Reset then WAIT_CYCLES=2: store addr 0x10, wdata 0xDEADBEEF, be 4'hF. rsp_valid rises 3 cycles after acceptance with rsp_err=0, rdata=0. A following load of 0x10 returns 0xDEADBEEF.
- Byte-lane merge: after storing 0xDEADBEEF, store addr 0x10, wdata 0x0000AA00, be 4'b0010. A load returns 0xDEADAAEF.
- Backpressure: load with rsp_ready=0 held 5 cycles. rsp_valid stays 1 and rdata stays constant; req_ready stays 0 until 1 cycle after rsp_ready=1 handshake.
- Out of range, DEPTH=256: load 0x400 returns rsp_err=1, rdata=0. Store 0x400 returns rsp_err=1, and a load of 0x0 is unchanged.
- Reset mid-WAIT: store to 0x20 (old value 0x12345678), assert rst during WAIT. After release, load 0x20 returns 0x12345678; rsp_valid=0 and req_ready=0 during reset.
- WAIT_CYCLES=0 back-to-back loads with rsp_ready tied 1: rsp_valid 1 cycle after each acceptance, one transaction per 2 cycles. With DMEM_ALIGN_CHECK_EN, load 0x12 returns rsp_err=1.
